// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator sharing one period counter.
// Each channel's duty is loaded through a valid/ready handshake into a shadow
// register and copied into the active register only at a period boundary.
module pwm_bank #(
    parameter int unsigned CHANNELS = 6,
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned OFFSET   = 0,
    parameter int unsigned CENTER   = 0
) (
    input  logic                      CLOCK_50,
    input  logic                      RESET_N,
    input  logic [CHANNELS*WIDTH-1:0] duty_in,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [CHANNELS-1:0]       ch_enable,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start
);

    localparam logic [WIDTH-1:0] CntMax = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);
    localparam logic [WIDTH-1:0] Offs   = WIDTH'(OFFSET);
    localparam logic [15:0]      PreMax = 16'(PRESCALE - 1);

    typedef enum logic {StEmpty, StFull} pend_e;

    logic [15:0]      pre_q, pre_d;
    logic             tick;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dir_down_q, dir_down_d;
    logic             bnd;
    pend_e            pending_q;
    logic [WIDTH-1:0] shadow_q [CHANNELS];
    logic [WIDTH-1:0] active_q [CHANNELS];
    logic [CHANNELS-1:0] pwm_d;

    assign tick       = (pre_q == PreMax);
    assign pre_d      = tick ? 16'd0 : pre_q + 16'd1;
    // Ready depends on the buffer state only, never on load_valid.
    assign load_ready = (pending_q == StEmpty);

    // Next counter value, direction and boundary detection.
    always_comb begin
        cnt_d      = cnt_q;
        dir_down_d = dir_down_q;
        bnd        = 1'b0;
        if (tick) begin
            if (CENTER == 0) begin
                cnt_d = cnt_q + 1'b1;
                bnd   = (cnt_q == CntMax);
            end else if (!dir_down_q) begin
                if (cnt_q == CntMax) begin
                    cnt_d      = cnt_q - 1'b1;
                    dir_down_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
                // Going down through 1 means the next count is 0: period ends.
                if (cnt_q == CntOne) begin
                    dir_down_d = 1'b0;
                    bnd        = 1'b1;
                end
            end
        end
    end

    // Prescaler, period counter and direction flag.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_q      <= '0;
            cnt_q      <= '0;
            dir_down_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            dir_down_q <= dir_down_d;
        end
    end

    // Double-buffer handshake: capture into shadow when empty, apply at boundary when full.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pending_q <= StEmpty;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            unique case (pending_q)
                StEmpty: begin
                    if (load_valid) begin
                        for (int i = 0; i < int'(CHANNELS); i++) begin
                            shadow_q[i] <= duty_in[i*WIDTH +: WIDTH] + Offs;
                        end
                        pending_q <= StFull;
                    end
                end
                StFull: begin
                    if (bnd) begin
                        for (int i = 0; i < int'(CHANNELS); i++) begin
                            active_q[i] <= shadow_q[i];
                        end
                        pending_q <= StEmpty;
                    end
                end
                default: pending_q <= StEmpty;
            endcase
        end
    end

    // Per-channel compare; enable is applied directly, not buffered.
    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            pwm_d[i] = ch_enable[i] & (cnt_q < active_q[i]);
        end
    end

    // Registered outputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            pwm_out      <= pwm_d;
            period_start <= bnd;
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: four pwm_bank instances (edge/center, several prescales and offsets)
// share one stimulus stream; a time-based reference model feeds a scoreboard queue.
module tb_pwm_bank;

    localparam int CH = 2;
    localparam int W  = 4;
    localparam int NI = 4;

    function automatic int pre_of(input int k);
        case (k)
            0: return 1;
            1: return 1;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int cen_of(input int k);
        return (k == 1 || k == 3) ? 1 : 0;
    endfunction

    function automatic int off_of(input int k);
        return (k == 1) ? 8 : 0;
    endfunction

    logic              clk;
    logic              rst_n;
    logic [CH*W-1:0]   duty_in;
    logic              load_valid;
    logic [CH-1:0]     ch_enable;
    logic              rdy [NI];
    logic [CH-1:0]     pwm [NI];
    logic              ps  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pwm_bank #(
            .CHANNELS(CH),
            .WIDTH   (W),
            .PRESCALE(pre_of(g)),
            .OFFSET  (off_of(g)),
            .CENTER  (cen_of(g))
        ) u_dut (
            .CLOCK_50    (clk),
            .RESET_N     (rst_n),
            .duty_in     (duty_in),
            .load_valid  (load_valid),
            .load_ready  (rdy[g]),
            .ch_enable   (ch_enable),
            .pwm_out     (pwm[g]),
            .period_start(ps[g])
        );
    end

    typedef struct packed {
        logic [NI*CH-1:0] pwm;
        logic [NI-1:0]    ps;
        logic [NI-1:0]    rdy;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: clocks since reset release plus the buffered duties.
    int ck     [NI];
    bit pend   [NI];
    int shadow [NI][CH];
    int active [NI][CH];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d t=%0t: got %0d expected %0d", name, k, $time, act, exp);
        end
    endtask

    // Position in the period is derived from elapsed clocks; the count value is
    // the position folded for center mode.
    task automatic model_step(output exp_t e);
        int p, len, ticks, pos, cv;
        bit tk, bnd;
        e = '0;
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                ck[k]   = 0;
                pend[k] = 0;
                for (int c = 0; c < CH; c++) begin
                    shadow[k][c] = 0;
                    active[k][c] = 0;
                end
                e.rdy[k] = 1'b1;
            end else begin
                p     = pre_of(k);
                len   = cen_of(k) ? 2 * ((1 << W) - 1) : (1 << W);
                ticks = ck[k] / p;
                tk    = (ck[k] % p) == p - 1;
                pos   = ticks % len;
                cv    = (cen_of(k) != 0 && pos >= (1 << W)) ? len - pos : pos;
                bnd   = tk && ((pos + 1) % len == 0);
                for (int c = 0; c < CH; c++) begin
                    e.pwm[k*CH + c] = ch_enable[c] & (cv < active[k][c]);
                end
                e.ps[k] = bnd;
                if (!pend[k]) begin
                    if (load_valid) begin
                        for (int c = 0; c < CH; c++) begin
                            shadow[k][c] = (int'(duty_in[c*W +: W]) + off_of(k)) % (1 << W);
                        end
                        pend[k] = 1;
                    end
                end else if (bnd) begin
                    for (int c = 0; c < CH; c++) active[k][c] = shadow[k][c];
                    pend[k] = 0;
                end
                e.rdy[k] = !pend[k];
                ck[k]++;
            end
        end
    endtask

    // Model: one expectation per active edge, from the inputs present at that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            model_step(e);
            q.push_back(e);
        end
    end

    // Monitor: outputs are presented every clock; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < NI; k++) begin
                    check("sb_pwm", k, 32'(pwm[k]), 32'(e.pwm[k*CH +: CH]));
                    check("sb_period_start", k, 32'(ps[k]), 32'(e.ps[k]));
                    check("sb_load_ready", k, 32'(rdy[k]), 32'(e.rdy[k]));
                end
            end
        end
    end

    function automatic bit all_ready();
        bit r = 1'b1;
        for (int k = 0; k < NI; k++) r = r & rdy[k];
        return r;
    endfunction

    task automatic do_load(input int d0, input int d1);
        int bud = 0;
        logic [W-1:0] a, b;
        load_valid = 1'b0;
        while (!all_ready() && bud < 400) begin
            @(negedge clk); #1;
            bud++;
        end
        a = W'(d0);
        b = W'(d1);
        duty_in    = {b, a};
        load_valid = 1'b1;
        @(negedge clk); #1;
        load_valid = 1'b0;
    endtask

    // Count high clocks over one full period with the newly applied duty.
    task automatic measure(input int k, input int d0, input int d1);
        int n = 0, h0 = 0, h1 = 0, bud = 0, p, e0, e1, len;
        p   = pre_of(k);
        e0  = (d0 + off_of(k)) % (1 << W);
        e1  = (d1 + off_of(k)) % (1 << W);
        len = cen_of(k) ? 2 * ((1 << W) - 1) : (1 << W);
        do begin
            @(negedge clk);
            bud++;
        end while (!(rdy[k] && ps[k]) && bud < 400);
        check("apply_pulse", k, 32'(ps[k]), 32'd1);
        do begin
            @(negedge clk);
            n++;
            h0 += int'(pwm[k][0]);
            h1 += int'(pwm[k][1]);
        end while (!ps[k] && n < 400);
        check("period_clocks", k, n, len * p);
        if (cen_of(k) != 0) begin
            check("high_ch0", k, h0, (e0 == 0 ? 0 : 2 * e0 - 1) * p);
            check("high_ch1", k, h1, (e1 == 0 ? 0 : 2 * e1 - 1) * p);
        end else begin
            check("high_ch0", k, h0, e0 * p);
            check("high_ch1", k, h1, e1 * p);
        end
    endtask

    task automatic load_and_measure(input int d0, input int d1);
        ch_enable = 2'b11;
        do_load(d0, d1);
        fork
            measure(0, d0, d1);
            measure(1, d0, d1);
            measure(2, d0, d1);
            measure(3, d0, d1);
        join
        @(negedge clk); #1;
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check("rst_pwm", k, 32'(pwm[k]), 32'd0);
            check("rst_period_start", k, 32'(ps[k]), 32'd0);
            check("rst_load_ready", k, 32'(rdy[k]), 32'd1);
        end
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        duty_in    = '0;
        load_valid = 1'b0;
        ch_enable  = 2'b11;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;

        load_and_measure(5, 0);
        load_and_measure(8, 3);
        load_and_measure(12, 7);
        load_and_measure(2, 15);

        // Reset while loads are pending: shadow contents must be discarded.
        do_load(9, 9);
        for (int k = 0; k < NI; k++) check("pending_before_reset", k, 32'(rdy[k]), 32'd0);
        pulse_reset();
        repeat (130) @(negedge clk);
        #1;

        // Randomised loads, back-pressure and enable toggling.
        for (int i = 0; i < 2500; i++) begin
            load_valid = ($urandom_range(0, 3) == 0);
            duty_in    = CH*W'($urandom);
            if ($urandom_range(0, 9) == 0) ch_enable = CH'($urandom_range(0, 3));
            if (i == 1300) pulse_reset();
            @(negedge clk); #1;
        end
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
